// File: rtl/paddle_debouncer_if.sv
// Paddle button bundle: raw buttons in, conditioned level/pulse outputs back.
// The debouncer uses the slave view; whatever drives the buttons and
// consumes the pulses uses the master view.
interface paddle_debouncer_if;
   logic left_btn;
   logic right_btn;
   logic left_state;
   logic left_down;
   logic left_up;
   logic left_hit;
   logic right_state;
   logic right_down;
   logic right_up;
   logic right_hit;

   modport master (
      output left_btn, right_btn,
      input  left_state, left_down, left_up, left_hit,
      input  right_state, right_down, right_up, right_hit
   );

   modport slave (
      input  left_btn, right_btn,
      output left_state, left_down, left_up, left_hit,
      output right_state, right_down, right_up, right_hit
   );
endinterface

// File: rtl/paddle_debouncer.sv
// Two-channel paddle button conditioner. Each channel synchronises its raw
// button, debounces it with a stability counter, emits registered level and
// press/release pulses, and gates the press pulse through a hold-off so one
// swing cannot retrigger the ball. Channel 0 is left, channel 1 is right.
module paddle_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int HOLDOFF_CYCLES  = 5000000
) (
   input  logic              clk,
   input  logic              reset,
   paddle_debouncer_if.slave bus
);
   localparam int              CW        = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam int              HW        = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
   localparam logic [HW-1:0]   HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? HW'(HOLDOFF_CYCLES - 1) : '0;

   logic [1:0] btn;
   logic [1:0] state_o;
   logic [1:0] down_o;
   logic [1:0] up_o;
   logic [1:0] hit_o;

   assign btn = {bus.right_btn, bus.left_btn};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_chan
         logic          sync1_reg;
         logic          sync2_reg;
         logic          state_reg, state_next;
         logic [CW-1:0] cnt_reg, cnt_next;
         logic          down_reg, down_next;
         logic          up_reg, up_next;
         logic          hit_reg, hit_next;

         // Two-flop synchroniser for the asynchronous raw button.
         always_ff @(posedge clk) begin
            if (reset) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
            end else begin
               sync1_reg <= btn[gi];
               sync2_reg <= sync1_reg;
            end
         end

         // Stability counter: flip the level only after it has disagreed for the full window.
         always_comb begin
            state_next = state_reg;
            cnt_next   = '0;
            down_next  = 1'b0;
            up_next    = 1'b0;
            if (sync2_reg != state_reg) begin
               if (cnt_reg == CNT_LAST) begin
                  state_next = ~state_reg;
                  down_next  = ~state_reg;
                  up_next    = state_reg;
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
         end

         if (HOLDOFF_CYCLES == 0) begin : g_nohold
            assign hit_next = down_next;
         end else begin : g_hold
            logic [HW-1:0] hcnt_reg, hcnt_next;

            // A press only counts as a hit when the hold-off has fully drained;
            // presses during hold-off are dropped and do not restart it.
            assign hit_next = down_next && (hcnt_reg == '0);

            // Hold-off countdown, reloaded only by an accepted hit.
            always_comb begin
               hcnt_next = hcnt_reg;
               if (hit_next) begin
                  hcnt_next = HOLD_LOAD;
               end else if (hcnt_reg != '0) begin
                  hcnt_next = hcnt_reg - HW'(1);
               end
            end

            // Hold-off counter register.
            always_ff @(posedge clk) begin
               if (reset) begin
                  hcnt_reg <= '0;
               end else begin
                  hcnt_reg <= hcnt_next;
               end
            end
         end

         // Registered level, counter and pulse outputs.
         always_ff @(posedge clk) begin
            if (reset) begin
               state_reg <= 1'b0;
               cnt_reg   <= '0;
               down_reg  <= 1'b0;
               up_reg    <= 1'b0;
               hit_reg   <= 1'b0;
            end else begin
               state_reg <= state_next;
               cnt_reg   <= cnt_next;
               down_reg  <= down_next;
               up_reg    <= up_next;
               hit_reg   <= hit_next;
            end
         end

         assign state_o[gi] = state_reg;
         assign down_o[gi]  = down_reg;
         assign up_o[gi]    = up_reg;
         assign hit_o[gi]   = hit_reg;
      end
   endgenerate

   assign bus.left_state  = state_o[0];
   assign bus.left_down   = down_o[0];
   assign bus.left_up     = up_o[0];
   assign bus.left_hit    = hit_o[0];
   assign bus.right_state = state_o[1];
   assign bus.right_down  = down_o[1];
   assign bus.right_up    = up_o[1];
   assign bus.right_hit   = hit_o[1];
endmodule

// File: tb/tb_paddle_debouncer.sv
// Bench for paddle_debouncer: three instances (hold-off 10, 30 and 0) share
// the same buttons and are compared every cycle against a history-based
// model, plus a directed table and hand-written corner sequences.
module tb_paddle_debouncer;
   localparam int D = 4;

   typedef struct {
      bit       rst;
      bit       lb;
      bit       rb;
      bit [7:0] exp;   // {ls, ld, lu, lh, rs, rd, ru, rh} of the hold-off-10 instance
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic lb;
   logic rb;

   always #5 clk = ~clk;

   paddle_debouncer_if if_a ();
   paddle_debouncer_if if_b ();
   paddle_debouncer_if if_c ();

   assign if_a.left_btn  = lb;
   assign if_a.right_btn = rb;
   assign if_b.left_btn  = lb;
   assign if_b.right_btn = rb;
   assign if_c.left_btn  = lb;
   assign if_c.right_btn = rb;

   paddle_debouncer #(.DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(10)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
   paddle_debouncer #(.DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(30)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
   paddle_debouncer #(.DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(0))  dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

   logic [7:0] got [3];
   assign got[0] = {if_a.left_state, if_a.left_down, if_a.left_up, if_a.left_hit,
                    if_a.right_state, if_a.right_down, if_a.right_up, if_a.right_hit};
   assign got[1] = {if_b.left_state, if_b.left_down, if_b.left_up, if_b.left_hit,
                    if_b.right_state, if_b.right_down, if_b.right_up, if_b.right_hit};
   assign got[2] = {if_c.left_state, if_c.left_down, if_c.left_up, if_c.left_hit,
                    if_c.right_state, if_c.right_down, if_c.right_up, if_c.right_hit};

   // Reference model: raw sample history since reset; s seen at edge k is the
   // raw value sampled two edges earlier. The level flips when the D most
   // recent s values since the last flip all disagree with it.
   bit raw_q [2][$];
   int edge_n;
   int last_flip [2];
   bit m_state [2];
   bit m_down [2];
   bit m_up [2];
   int last_hit [3][2];
   bit m_hit [3][2];

   int vectors = 0;
   int miscompares = 0;

   function automatic int hold_of(int i);
      case (i)
         0:       return 10;
         1:       return 30;
         default: return 0;
      endcase
   endfunction

   task automatic model_edge(bit r, bit l, bit rr);
      if (r) begin
         edge_n = 0;
         for (int ch = 0; ch < 2; ch++) begin
            raw_q[ch].delete();
            last_flip[ch] = -1;
            m_state[ch] = 1'b0;
            m_down[ch] = 1'b0;
            m_up[ch] = 1'b0;
            for (int i = 0; i < 3; i++) begin
               last_hit[i][ch] = -1000000;
               m_hit[i][ch] = 1'b0;
            end
         end
      end else begin
         for (int ch = 0; ch < 2; ch++) begin
            bit all_diff;
            raw_q[ch].push_back(ch == 0 ? l : rr);
            m_down[ch] = 1'b0;
            m_up[ch] = 1'b0;
            if (edge_n - D + 1 > last_flip[ch]) begin
               all_diff = 1'b1;
               for (int k = edge_n - D + 1; k <= edge_n; k++) begin
                  bit s;
                  s = (k >= 2) ? raw_q[ch][k-2] : 1'b0;
                  if (s == m_state[ch]) all_diff = 1'b0;
               end
               if (all_diff) begin
                  m_state[ch] = ~m_state[ch];
                  last_flip[ch] = edge_n;
                  m_down[ch] = m_state[ch];
                  m_up[ch] = ~m_state[ch];
               end
            end
            for (int i = 0; i < 3; i++) begin
               m_hit[i][ch] = m_down[ch] && (edge_n - last_hit[i][ch] >= hold_of(i));
               if (m_hit[i][ch]) last_hit[i][ch] = edge_n;
            end
         end
         edge_n++;
      end
   endtask

   function automatic logic [7:0] exp_of(int i);
      return {m_state[0], m_down[0], m_up[0], m_hit[i][0],
              m_state[1], m_down[1], m_up[1], m_hit[i][1]};
   endfunction

   task automatic check_all(string tag);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (got[i] !== exp_of(i)) begin
            miscompares++;
            $display("FAIL %s dut%0d outputs got %b want %b", tag, i, got[i], exp_of(i));
         end
      end
   endtask

   task automatic expect_bit(string name, logic actual, logic want);
      vectors++;
      if (actual !== want) begin
         miscompares++;
         $display("FAIL %s got %b want %b", name, actual, want);
      end
   endtask

   // Drive at the falling edge, model at the rising edge, compare at the next falling edge.
   task automatic step(bit r, bit l, bit rr, string tag);
      reset = r;
      lb = l;
      rb = rr;
      @(posedge clk);
      model_edge(r, l, rr);
      @(negedge clk);
      check_all(tag);
   endtask

   vec_t tbl [19];

   task automatic set_row(int i, bit r, bit l, bit rr, bit [7:0] x);
      tbl[i].rst = r;
      tbl[i].lb = l;
      tbl[i].rb = rr;
      tbl[i].exp = x;
   endtask

   initial begin
      bit seen;
      reset = 1'b1;
      lb = 1'b0;
      rb = 1'b0;

      // Reset for 3 cycles, then left press sampled at row 4 -> flip at row 9, release at 12 -> up at 17.
      for (int i = 0; i < 3; i++) set_row(i, 1'b1, 1'b0, 1'b0, 8'b0000_0000);
      set_row(3, 1'b0, 1'b0, 1'b0, 8'b0000_0000);
      for (int i = 4; i < 9; i++) set_row(i, 1'b0, 1'b1, 1'b0, 8'b0000_0000);
      set_row(9, 1'b0, 1'b1, 1'b0, 8'b1101_0000);
      set_row(10, 1'b0, 1'b1, 1'b0, 8'b1000_0000);
      set_row(11, 1'b0, 1'b1, 1'b0, 8'b1000_0000);
      for (int i = 12; i < 17; i++) set_row(i, 1'b0, 1'b0, 1'b0, 8'b1000_0000);
      set_row(17, 1'b0, 1'b0, 1'b0, 8'b0010_0000);
      set_row(18, 1'b0, 1'b0, 1'b0, 8'b0000_0000);

      @(negedge clk);
      for (int i = 0; i < 19; i++) begin
         step(tbl[i].rst, tbl[i].lb, tbl[i].rb, "table");
         vectors++;
         if (got[0] !== tbl[i].exp) begin
            miscompares++;
            $display("FAIL table_row%0d got %b want %b", i, got[0], tbl[i].exp);
         end
         $display("row %0d rst=%0b lb=%0b rb=%0b outputs=%b", i, tbl[i].rst, tbl[i].lb, tbl[i].rb, got[0]);
      end

      // Glitches of 3 cycles never reach the debounced level.
      seen = 1'b0;
      for (int rep = 0; rep < 4; rep++) begin
         for (int k = 0; k < 6; k++) begin
            step(1'b0, k < 3, 1'b0, "glitch");
            seen = seen | if_a.left_state | if_a.left_down | if_a.left_hit;
         end
      end
      for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0, "idle");
      expect_bit("glitch_no_left_activity", seen, 1'b0);
      $display("glitch sequence done left_activity=%0b", seen);

      // Right press, release, re-press: hit again once hold-off 10 has drained, still blocked for 30.
      for (int k = 0; k < 26; k++) begin
         step(1'b0, 1'b0, (k < 8) || (k >= 14), "right_seq");
         if (k == 5) expect_bit("right_first_hit", if_a.right_hit, 1'b1);
         if (k == 13) expect_bit("right_up", if_a.right_up, 1'b1);
         if (k == 19) begin
            expect_bit("right_redown", if_a.right_down, 1'b1);
            expect_bit("right_rehit_h10", if_a.right_hit, 1'b1);
            expect_bit("right_rehit_h30_blocked", if_b.right_hit, 1'b0);
            expect_bit("right_rehit_h0", if_c.right_hit, 1'b1);
         end
      end
      for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0, "idle");
      $display("right press/release/re-press sequence done");

      // Both buttons rise together: both hits in the same cycle.
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 1'b1, 1'b1, "both");
         if (k == 5) begin
            expect_bit("both_left_hit", if_a.left_hit, 1'b1);
            expect_bit("both_right_hit", if_a.right_hit, 1'b1);
         end
      end
      for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0, "idle");
      $display("simultaneous press sequence done");

      // Reset one cycle before the flip: no down then, fresh down 5 cycles after release.
      for (int k = 0; k < 13; k++) begin
         step(k == 4, 1'b1, 1'b0, "reset_mid");
         if (k == 4) expect_bit("reset_mid_no_down", if_a.left_down, 1'b0);
         if (k == 9) expect_bit("reset_mid_state_still_low", if_a.left_state, 1'b0);
         if (k == 10) begin
            expect_bit("reset_mid_down", if_a.left_down, 1'b1);
            expect_bit("reset_mid_hit", if_a.left_hit, 1'b1);
         end
      end
      for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0, "idle");
      $display("reset mid-count sequence done");

      // Random button activity with occasional resets, checked cycle by cycle.
      for (int n = 0; n < 3000; n++) begin
         bit r;
         bit l;
         bit rr;
         l = ($urandom_range(0, 5) == 0) ? ~lb : lb;
         rr = ($urandom_range(0, 5) == 0) ? ~rb : rb;
         r = ($urandom_range(0, 399) == 0);
         step(r, l, rr, "random");
      end
      $display("random phase done");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
